// File: rtl/fp_to_int_converter.sv
// fp_to_int_converter: IEEE754 single -> signed OUT_W-bit integer, truncating toward zero, bit-serial
// Ports: clk, reset (sync, active-high), start (request pulse), numb (IEEE754 operand),
//        busy (conversion in flight), done (one-cycle result pulse), result (signed integer),
//        fp_class (0 zero, 1 subnormal, 2 normal, 3 inf, 4 NaN), error (NaN, Inf or overflow)
module fp_to_int_converter #(
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      numb,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] result,
   output logic [2:0]       fp_class,
   output logic             error
);
   typedef enum logic [2:0] {IDLE, DECODE, SHIFT, SIGN, DONE} state_t;
   localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [8:0] E_TOP = 9'(OUT_W - 1);
   state_t state_q, state_d;
   logic [31:0] numb_q;
   logic [OUT_W-1:0] acc_q, acc_d, res_d, sat;
   logic [5:0] cnt_q, cnt_d, n;
   logic [2:0] cls_d;
   logic err_d, load, s, left;
   logic [7:0] e;
   logic [22:0] m;
   logic signed [8:0] e_x, d;
   assign s = numb_q[31];
   assign e = numb_q[30:23];
   assign m = numb_q[22:0];
   assign e_x = $signed({1'b0, e}) - 9'sd127;
   // distance from the binary point of {1,m}; sign picks shift direction
   assign d = e_x - 9'sd23;
   assign left = !d[8];
   assign n = left ? d[5:0] : 6'(-d);
   assign sat = s ? MIN_NEG : MAX_POS;
   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      load = 1'b0;
      res_d = '0;
      cls_d = 3'd2;
      err_d = 1'b0;
      case (state_q)
         IDLE: state_d = start ? DECODE : IDLE;
         DECODE: begin
            state_d = DONE;
            load = 1'b1;
            if (e == 8'd0) cls_d = (m == '0) ? 3'd0 : 3'd1;
            else if (e == 8'hFF) begin
               cls_d = (m == '0) ? 3'd3 : 3'd4;
               err_d = 1'b1;
               res_d = (m == '0) ? sat : '0;
            end else if (e_x >= E_TOP) begin
               // -2^(OUT_W-1) is exactly representable, everything else here overflows
               res_d = sat;
               err_d = !(s && e_x == E_TOP && m == '0);
            end else if (!e_x[8]) begin
               load = 1'b0;
               acc_d = OUT_W'({1'b1, m});
               cnt_d = n;
               state_d = (n == 6'd0) ? SIGN : SHIFT;
            end
         end
         SHIFT: begin
            acc_d = left ? acc_q << 1 : acc_q >> 1;
            cnt_d = cnt_q - 6'd1;
            state_d = (cnt_q == 6'd1) ? SIGN : SHIFT;
         end
         SIGN: begin
            state_d = DONE;
            load = 1'b1;
            res_d = s ? -acc_q : acc_q;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // outputs load on the edge entering DONE so they are valid while done is high
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         result <= '0;
         fp_class <= '0;
         error <= 1'b0;
         acc_q <= '0;
         cnt_q <= '0;
         numb_q <= '0;
      end else begin
         state_q <= state_d;
         busy <= state_d != IDLE;
         done <= state_d == DONE;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         if (state_q == IDLE && start) numb_q <= numb;
         if (load) begin
            result <= res_d;
            fp_class <= cls_d;
            error <= err_d;
         end
      end
   end
endmodule

// File: tb/tb_fp_to_int_converter.sv
// tb_fp_to_int_converter: directed vectors checked against an arithmetic model every cycle
module tb_fp_to_int_converter;
   logic clk, reset, start, busy, done, error;
   logic [31:0] numb, result;
   logic [2:0] fp_class;
   int checks = 0, errors = 0, cyc = 0, c0 = 0;
   logic active = 1'b0, r, dexp, bexp;
   logic [31:0] m_res, exp_res = '0;
   logic [2:0] m_cls, exp_cls = '0;
   logic m_err, exp_err = 1'b0;
   int m_lat;

   fp_to_int_converter #(.OUT_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .numb(numb),
      .busy(busy), .done(done), .result(result), .fp_class(fp_class), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   // value = 1.m * 2^E, truncated toward zero, saturated to 32-bit signed
   function automatic void model(input logic [31:0] x, output logic [31:0] res,
                                 output logic [2:0] cls, output logic err, output int lat);
      int ex, ee;
      logic [63:0] mag;
      ex = int'(x[30:23]);
      ee = ex - 127;
      res = '0;
      err = 1'b0;
      lat = 2;
      cls = 3'd2;
      if (ex == 0) cls = (x[22:0] == 0) ? 3'd0 : 3'd1;
      else if (ex == 255) begin
         cls = (x[22:0] == 0) ? 3'd3 : 3'd4;
         err = 1'b1;
         if (x[22:0] == 0) res = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else if (ee >= 31) begin
         res = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         err = !(x[31] && ee == 31 && x[22:0] == 0);
      end else if (ee >= 0) begin
         mag = 64'(32'h0080_0000 + 32'(x[22:0]));
         mag = (ee >= 23) ? mag << (ee - 23) : mag >> (23 - ee);
         res = x[31] ? 32'(-mag) : 32'(mag);
         lat = ((ee >= 23) ? ee - 23 : 23 - ee) + 3;
      end
   endfunction

   always @(posedge clk) begin
      cyc++;
      r = reset;
      #2;
      if (r) begin
         active = 1'b0;
         exp_res = '0;
         exp_cls = '0;
         exp_err = 1'b0;
      end
      dexp = active && cyc == c0 + m_lat;
      bexp = active && cyc > c0 && cyc <= c0 + m_lat;
      if (dexp) begin
         exp_res = m_res;
         exp_cls = m_cls;
         exp_err = m_err;
         active = 1'b0;
      end
      chk("busy", 64'(busy), 64'(bexp));
      chk("done", 64'(done), 64'(dexp));
      chk("result", 64'(result), 64'(exp_res));
      chk("class", 64'(fp_class), 64'(exp_cls));
      chk("error", 64'(error), 64'(exp_err));
   end

   task automatic launch(input logic [31:0] x);
      model(x, m_res, m_cls, m_err, m_lat);
      c0 = cyc;
      active = 1'b1;
      numb = x;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run(input logic [31:0] x, input logic [31:0] lr, input logic [2:0] lc,
                      input logic le, input int ll, input int g);
      logic seen;
      launch(x);
      chk("model_res", 64'(m_res), 64'(lr));
      chk("model_cls", 64'(m_cls), 64'(lc));
      chk("model_err", 64'(m_err), 64'(le));
      chk("model_lat", 64'(m_lat), 64'(ll));
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         start = (g > 0 && cyc == c0 + g);
         if (start) numb = 32'h4B00_0001;
      end
      start = 1'b0;
      chk("done_seen", 64'(seen), 64'd1);
      chk("latency", 64'(cyc - c0), 64'(ll));
      chk("dut_result", 64'(result), 64'(lr));
      @(negedge clk);
   endtask

   initial begin
      logic seen;
      reset = 1'b1;
      start = 1'b0;
      numb = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run(32'h3FC0_0000, 32'd1, 3'd2, 1'b0, 26, 0);
      run(32'h42F6_E979, 32'd123, 3'd2, 1'b0, 20, 0);
      run(32'hC2F6_0000, 32'hFFFF_FF85, 3'd2, 1'b0, 20, 0);
      run(32'h4B00_0001, 32'd8388609, 3'd2, 1'b0, 3, 0);
      run(32'h4F00_0000, 32'h7FFF_FFFF, 3'd2, 1'b1, 2, 0);
      run(32'hCF00_0000, 32'h8000_0000, 3'd2, 1'b0, 2, 0);
      run(32'h7FC0_0000, 32'd0, 3'd4, 1'b1, 2, 0);
      run(32'hFF80_0000, 32'h8000_0000, 3'd3, 1'b1, 2, 0);
      run(32'h0000_0001, 32'd0, 3'd1, 1'b0, 2, 0);
      run(32'h3F00_0000, 32'd0, 3'd2, 1'b0, 2, 0);
      run(32'hC049_0FDB, 32'hFFFF_FFFD, 3'd2, 1'b0, 25, 0);
      run(32'h4EFF_FFFF, 32'h7FFF_FF80, 3'd2, 1'b0, 10, 0);
      run(32'hCEFF_FFFF, 32'h8000_0080, 3'd2, 1'b0, 10, 0);
      run(32'h8000_0000, 32'd0, 3'd0, 1'b0, 2, 0);
      run(32'h3FC0_0000, 32'd1, 3'd2, 1'b0, 26, 5);
      run(32'hFF80_0000, 32'h8000_0000, 3'd3, 1'b1, 2, 0);
      launch(32'h3FC0_0000);
      while (cyc < c0 + 10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("rst_no_done", 64'(seen), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_class", 64'(fp_class), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      run(32'h7FC0_0000, 32'd0, 3'd4, 1'b1, 2, 0);
      reset = 1'b1;
      start = 1'b1;
      numb = 32'h4B00_0001;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_start_busy", 64'(busy), 64'd0);
      run(32'h4B00_0001, 32'd8388609, 3'd2, 1'b0, 3, 0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
